// File: rtl/accelerator_convolutional_fnn_vector_sender.sv
// accelerator_convolutional_fnn_vector_sender
// Holds up to DEPTH vector elements and streams them into the convolutional
// FNN datapath. Element 0 goes out on the cycle after START. Each later
// element follows a DATA_ENABLE request from the consumer.
// Optional feature macro: ACCELERATOR_CONVOLUTIONAL_FNN_REVERSE_EN. It adds a
// REVERSE input that emits the vector in descending index order.
module accelerator_convolutional_fnn_vector_sender #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int DEPTH        = 64,
    parameter int ADDR_SIZE    = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WRITE_ENABLE,
    input  logic [ADDR_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0] WRITE_DATA,
`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_REVERSE_EN
    input  logic                 REVERSE,
`endif
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic                 DATA_ENABLE,
    output logic                 DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic [ADDR_SIZE-1:0] INDEX_OUT,
    output logic                 BUSY,
    output logic                 READY,
    output logic                 ERROR
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_REQUEST,
        DONE
    } state_t;

    // The length check uses the full SIZE_IN width, so large values with
    // small low bits are still rejected.
    localparam logic [DATA_SIZE-1:0] MAX_LEN = DATA_SIZE'(DEPTH);
    localparam logic [ADDR_SIZE-1:0] ONE     = ADDR_SIZE'(1);

    logic [DATA_SIZE-1:0] buffer_mem [DEPTH];

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] index_q, index_d;
    logic [ADDR_SIZE-1:0] last_q, last_d;
    logic [ADDR_SIZE-1:0] index_out_q, index_out_d;
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 reverse_q, reverse_d;
    logic                 error_q, error_d;

    logic                 buffer_we;
    logic                 reverse_in;
    logic                 size_illegal;
    logic [ADDR_SIZE-1:0] size_last;
    logic [ADDR_SIZE-1:0] final_index;

`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_REVERSE_EN
    assign reverse_in = REVERSE;
`else
    assign reverse_in = 1'b0;
`endif

    assign size_illegal = (SIZE_IN == '0) || (SIZE_IN > MAX_LEN);
    assign size_last    = SIZE_IN[ADDR_SIZE-1:0] - ONE;
    assign final_index  = reverse_q ? '0 : last_q;

    // Buffer storage has no reset, so vector contents survive a reset.
    always_ff @(posedge CLK) begin
        if (buffer_we) begin
            buffer_mem[WRITE_ADDRESS] <= WRITE_DATA;
        end
    end

    // State, index and output-hold registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            index_q     <= '0;
            last_q      <= '0;
            index_out_q <= '0;
            data_out_q  <= '0;
            reverse_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            last_q      <= last_d;
            index_out_q <= index_out_d;
            data_out_q  <= data_out_d;
            reverse_q   <= reverse_d;
            error_q     <= error_d;
        end
    end

    // Next-state logic. The buffer is read only in SEND. While a transfer
    // runs the buffer cannot change, so element 0 sees any write that
    // arrived together with START.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        last_d      = last_q;
        reverse_d   = reverse_q;
        error_d     = 1'b0;
        buffer_we   = 1'b0;
        data_out_d  = data_out_q;
        index_out_d = index_out_q;

        case (state_q)
            IDLE: begin
                buffer_we = WRITE_ENABLE;
                if (START) begin
                    if (size_illegal) begin
                        error_d = 1'b1;
                    end else begin
                        last_d    = size_last;
                        reverse_d = reverse_in;
                        index_d   = reverse_in ? size_last : '0;
                        state_d   = SEND;
                    end
                end
            end
            SEND: begin
                data_out_d  = buffer_mem[index_q];
                index_out_d = index_q;
                if (index_q == final_index) begin
                    state_d = DONE;
                end else begin
                    index_d = reverse_q ? (index_q - ONE) : (index_q + ONE);
                    state_d = WAIT_REQUEST;
                end
            end
            WAIT_REQUEST: begin
                if (DATA_ENABLE) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobe and status outputs come from the state. DATA_OUT and INDEX_OUT
    // show the live element in SEND and hold it between strobes.
    always_comb begin
        DATA_OUT_ENABLE = (state_q == SEND);
        DATA_OUT        = data_out_d;
        INDEX_OUT       = index_out_d;
        BUSY            = (state_q == SEND) || (state_q == WAIT_REQUEST);
        READY           = (state_q == DONE) || error_q;
        ERROR           = error_q;
    end

endmodule

// File: tb/tb_accelerator_convolutional_fnn_vector_sender.sv
// Testbench for accelerator_convolutional_fnn_vector_sender.
// A transaction-level model (buffer array plus a queue of indices still to
// send) predicts every output on every cycle. Directed scenarios pin the
// model with hand-computed literals. A randomized phase then stresses it.
module tb_accelerator_convolutional_fnn_vector_sender;

    localparam int DW    = 64;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk           = 1'b0;
    logic          rst_n         = 1'b0;
    logic          write_enable  = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [DW-1:0] write_data    = '0;
    logic          start         = 1'b0;
    logic [DW-1:0] size_in       = '0;
    logic          data_enable   = 1'b0;
    logic          reverse_drv   = 1'b0;

    logic          data_out_enable;
    logic [DW-1:0] data_out;
    logic [AW-1:0] index_out;
    logic          busy;
    logic          ready;
    logic          error;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    accelerator_convolutional_fnn_vector_sender dut (
        .CLK            (clk),
        .RST            (rst_n),
        .WRITE_ENABLE   (write_enable),
        .WRITE_ADDRESS  (write_address),
        .WRITE_DATA     (write_data),
`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_REVERSE_EN
        .REVERSE        (reverse_drv),
`endif
        .START          (start),
        .SIZE_IN        (size_in),
        .DATA_ENABLE    (data_enable),
        .DATA_OUT_ENABLE(data_out_enable),
        .DATA_OUT       (data_out),
        .INDEX_OUT      (index_out),
        .BUSY           (busy),
        .READY          (ready),
        .ERROR          (error)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural model state.
    logic [DW-1:0] model_buf [DEPTH];
    int            pend [$];
    bit            in_xfer    = 1'b0;
    logic          exp_strobe = 1'b0;
    logic [DW-1:0] exp_data   = '0;
    logic [AW-1:0] exp_index  = '0;
    logic          exp_busy   = 1'b0;
    logic          exp_ready  = 1'b0;
    logic          exp_error  = 1'b0;

    // Strobe and ready logs, used by the directed literal checks.
    logic [DW-1:0] sdata [$];
    int            sidx [$];
    int            scyc [$];
    int            rcyc [$];
    int            ecount = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One clock of model evolution.
    task automatic modelStep();
        bit done_cycle;
        bit idle;
        bit was_strobe;
        bit emit;
        bit rv;
        int n;
        int idx;
        if (!rst_n) begin
            pend.delete();
            in_xfer    = 1'b0;
            exp_strobe = 1'b0;
            exp_data   = '0;
            exp_index  = '0;
            exp_busy   = 1'b0;
            exp_ready  = 1'b0;
            exp_error  = 1'b0;
            return;
        end
`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_REVERSE_EN
        rv = reverse_drv;
`else
        rv = 1'b0;
`endif
        done_cycle = exp_ready && !exp_error;
        idle       = !in_xfer && !done_cycle;
        was_strobe = exp_strobe;
        emit       = 1'b0;
        exp_strobe = 1'b0;
        exp_ready  = 1'b0;
        exp_error  = 1'b0;
        if (idle) begin
            if (write_enable) model_buf[write_address] = write_data;
            if (start) begin
                if (size_in == 0 || size_in > DEPTH) begin
                    exp_ready = 1'b1;
                    exp_error = 1'b1;
                end else begin
                    n = int'(size_in);
                    for (int k = 0; k < n; k++) pend.push_back(rv ? n - 1 - k : k);
                    in_xfer = 1'b1;
                    emit    = 1'b1;
                end
            end
        end else if (in_xfer) begin
            if (was_strobe) begin
                if (pend.size() == 0) begin
                    in_xfer   = 1'b0;
                    exp_ready = 1'b1;
                end
            end else if (data_enable) begin
                emit = 1'b1;
            end
        end
        if (emit) begin
            idx        = pend.pop_front();
            exp_strobe = 1'b1;
            exp_data   = model_buf[idx];
            exp_index  = AW'(idx);
        end
        exp_busy = in_xfer;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        modelStep();
    end

    // Compare process: checks every output against the model on each falling edge.
    initial forever begin
        @(negedge clk);
        checkOutput("strobe", DW'(data_out_enable), DW'(exp_strobe));
        checkOutput("data",   data_out, exp_data);
        checkOutput("index",  DW'(index_out), DW'(exp_index));
        checkOutput("busy",   DW'(busy), DW'(exp_busy));
        checkOutput("ready",  DW'(ready), DW'(exp_ready));
        checkOutput("error",  DW'(error), DW'(exp_error));
        if (data_out_enable) begin
            sdata.push_back(data_out);
            sidx.push_back(int'(index_out));
            scyc.push_back(cyc);
        end
        if (ready) rcyc.push_back(cyc);
        if (error) ecount++;
    end

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic st, input logic [DW-1:0] sz, input logic de,
                                 input logic rv);
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        start         = st;
        size_in       = sz;
        data_enable   = de;
        reverse_drv   = rv;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic clearLogs();
        sdata.delete();
        sidx.delete();
        scyc.delete();
        rcyc.delete();
        ecount = 0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_strobe"}, DW'(data_out_enable), '0);
        checkOutput({tag, "_data"},   data_out, '0);
        checkOutput({tag, "_index"},  DW'(index_out), '0);
        checkOutput({tag, "_busy"},   DW'(busy), '0);
        checkOutput({tag, "_ready"},  DW'(ready), '0);
        checkOutput({tag, "_error"},  DW'(error), '0);
    endtask

    // Starts a transfer and plays the consumer. delay==0 holds DATA_ENABLE
    // high; otherwise the request comes delay cycles after each strobe.
    task automatic runTransfer(input logic [DW-1:0] sz, input logic rv, input int delay,
                               input int abort_at, input bit inject, input bit noise,
                               output int start_cycle);
        int            since;
        int            seen;
        bit            done;
        logic          we;
        logic          st;
        logic          de;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] nsz;
        start_cycle = cyc;
        applyStimulus(1'b0, '0, '0, 1'b1, sz, 1'b0, rv);
        since = 0;
        seen  = 0;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (data_out_enable) begin
                since = 0;
                seen++;
            end else begin
                since++;
            end
            if (ready) begin
                done = 1'b1;
            end else if (abort_at != 0 && seen == abort_at && data_out_enable) begin
                #2 rst_n = 1'b0;
                #1 checkResetOutputs("abort_reset");
                @(negedge clk);
                rst_n = 1'b1;
                done  = 1'b1;
            end else begin
                we  = 1'b0;
                wa  = '0;
                wd  = '0;
                st  = 1'b0;
                nsz = '0;
                de  = (delay == 0) ? 1'b1 : (since >= delay);
                if (inject && seen == 1 && since == 1) begin
                    we  = 1'b1;
                    wa  = AW'(2);
                    wd  = DW'(99);
                    st  = 1'b1;
                    nsz = DW'(4);
                end
                if (noise) begin
                    we  = ($urandom % 4) == 0;
                    wa  = AW'($urandom);
                    wd  = {$urandom, $urandom};
                    st  = ($urandom % 8) == 0;
                    nsz = DW'($urandom_range(0, 70));
                end
                applyStimulus(we, wa, wd, st, nsz, de, rv);
            end
        end
        if (!done) checkOutput("ready_timeout", '0, DW'(1));
    endtask

    // Literal check of a 4-element transfer of {10,20,30,40}.
    task automatic checkLog4(input string tag, input bit rv, input int t0);
        int vals [4];
        vals = '{10, 20, 30, 40};
        checkOutput({tag, "_count"}, DW'(sdata.size()), DW'(4));
        for (int k = 0; k < 4 && k < sdata.size(); k++) begin
            int e = rv ? 3 - k : k;
            checkOutput({tag, "_data"},  sdata[k], DW'(vals[e]));
            checkOutput({tag, "_index"}, DW'(sidx[k]), DW'(e));
        end
        if (scyc.size() > 0) checkOutput({tag, "_first_lat"}, DW'(scyc[0] - t0), DW'(1));
        checkOutput({tag, "_ready_count"}, DW'(rcyc.size()), DW'(1));
        if (rcyc.size() == 1 && scyc.size() == 4)
            checkOutput({tag, "_ready_lat"}, DW'(rcyc[0] - scyc[3]), DW'(1));
    endtask

    // Global time limit so the bench cannot hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int            t0;
        logic [DW-1:0] val;
        logic [DW-1:0] rsz;
        int            r;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("reset_state");
        rst_n = 1'b1;
        idleCycles(1);

        // Load the whole buffer: {10,20,30,40} at the bottom, random above.
        for (int a = 0; a < DEPTH; a++) begin
            val = (a < 4) ? DW'((a + 1) * 10) : {$urandom, $urandom};
            applyStimulus(1'b1, AW'(a), val, 1'b0, '0, 1'b0, 1'b0);
        end
        idleCycles(2);

        // Basic forward transfer, request two cycles after each strobe.
        clearLogs();
        runTransfer(DW'(4), 1'b0, 2, 0, 1'b0, 1'b0, t0);
        idleCycles(2);
        checkLog4("fwd", 1'b0, t0);
        checkOutput("fwd_busy_after", DW'(busy), '0);

        // Illegal sizes, including one whose low bits look legal.
        clearLogs();
        applyStimulus(1'b0, '0, '0, 1'b1, DW'(0), 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, '0, '0, 1'b1, DW'(65), 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, '0, '0, 1'b1, 64'h0000_0001_0000_0004, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("illegal_strobes", DW'(sdata.size()), '0);
        checkOutput("illegal_ready",   DW'(rcyc.size()), DW'(3));
        checkOutput("illegal_error",   DW'(ecount), DW'(3));
        checkOutput("illegal_busy",    DW'(busy), '0);

        // Continuous request: strobes on alternate cycles.
        clearLogs();
        runTransfer(DW'(3), 1'b0, 0, 0, 1'b0, 1'b0, t0);
        idleCycles(2);
        checkOutput("cont_count", DW'(scyc.size()), DW'(3));
        if (scyc.size() == 3) begin
            checkOutput("cont_t1", DW'(scyc[0] - t0), DW'(1));
            checkOutput("cont_t3", DW'(scyc[1] - t0), DW'(3));
            checkOutput("cont_t5", DW'(scyc[2] - t0), DW'(5));
        end
        if (rcyc.size() == 1) checkOutput("cont_ready_t6", DW'(rcyc[0] - t0), DW'(6));
        else checkOutput("cont_ready_count", DW'(rcyc.size()), DW'(1));

        // Write and START while busy are both ignored.
        clearLogs();
        runTransfer(DW'(4), 1'b0, 3, 0, 1'b1, 1'b0, t0);
        idleCycles(4);
        checkLog4("busy_ignore", 1'b0, t0);

        // Reset after the second element aborts the transfer.
        clearLogs();
        runTransfer(DW'(4), 1'b0, 1, 2, 1'b0, 1'b0, t0);
        idleCycles(4);
        checkOutput("abort_no_ready", DW'(rcyc.size()), '0);
        clearLogs();
        runTransfer(DW'(4), 1'b0, 1, 0, 1'b0, 1'b0, t0);
        idleCycles(2);
        checkLog4("after_reset", 1'b0, t0);

`ifdef ACCELERATOR_CONVOLUTIONAL_FNN_REVERSE_EN
        // Descending order.
        clearLogs();
        runTransfer(DW'(4), 1'b1, 2, 0, 1'b0, 1'b0, t0);
        idleCycles(2);
        checkLog4("reverse", 1'b1, t0);
`endif

        // Randomized phase, checked cycle by cycle against the model.
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                applyStimulus(1'b1, AW'($urandom), {$urandom, $urandom}, 1'b0, '0, 1'b0, 1'b0);
            r = int'($urandom % 10);
            case (r)
                0:       rsz = DW'(0);
                1:       rsz = DW'(65);
                2:       rsz = 64'h0000_0001_0000_0003;
                3:       rsz = DW'(64);
                default: rsz = DW'($urandom_range(1, 8));
            endcase
            runTransfer(rsz, 1'($urandom), int'($urandom_range(0, 3)), 0, 1'b0, 1'b1, t0);
            idleCycles(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
